vram_console: RTL and testbench
===============================

VRAM_CONSOLE -- requirements
Module: vram_console

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning rows per screen; COLS*ROWS SHALL be at most 2048.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; it also clocks the video RAM write port (vram_clk).
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits, the character byte.
REQ-006 SHALL have port in_valid, input, 1 bit, asserted when in_data holds a byte.
REQ-007 SHALL have port in_ready, output, 1 bit, asserted when the block can accept a byte.
REQ-008 SHALL have port in_attr, input, 8 bits, the attribute/colour byte sampled with each accepted byte.
REQ-009 SHALL have port vram_waddr, output, 11 bits, the cell address.
REQ-010 SHALL have port vram_wdata, output, 16 bits, written as {attr, char}.
REQ-011 SHALL have port vram_we, output, 1 bit, the write strobe.
REQ-012 SHALL have port busy, output, 1 bit, equal to the inverse of in_ready.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 SHALL hold cursor registers col (0..COLS-1) and row (0..ROWS-1) and an attribute register attr.
REQ-015 Cell address SHALL be row*COLS+col, computed exactly within 11 bits.
REQ-016 States SHALL be IDLE, PUT, LINECLR and CLRALL.
REQ-017 in_ready SHALL be 1 only in IDLE; a byte is accepted on a cycle where in_valid and in_ready are both 1.
REQ-018 On every accept, attr SHALL load in_attr.
REQ-019 Printable byte (0x20..0x7E) accepted: go to PUT.
- Next cycle: vram_we=1, vram_waddr=cursor address, vram_wdata={attr,byte}.
- Then col increments.
- If col was COLS-1: col=0, row advances with wrap, state goes to LINECLR; otherwise state goes to IDLE.
REQ-020 0x0A (LF): col=0 and row advances with wrap (ROWS-1 -> 0), then LINECLR; no PUT write.
REQ-021 0x0D (CR): col=0; stay in IDLE; no write.
REQ-022 0x08 (BS): col decrements if col>0, else unchanged; stay in IDLE; no write.
REQ-023 0x0C (FF): row=0, col=0, enter CLRALL.
REQ-024 All other bytes SHALL be consumed and ignored; the block stays in IDLE with no write.
REQ-025 LINECLR SHALL issue exactly COLS consecutive writes, one per cycle, vram_we=1.
- Addresses row*COLS+0 .. row*COLS+COLS-1, in order.
- Data {attr,8'h20}.
- Then return to IDLE.
REQ-026 CLRALL SHALL issue exactly COLS*ROWS consecutive writes, addresses 0..COLS*ROWS-1, data {attr,8'h20}, then return to IDLE.
REQ-027 vram_we SHALL be 0 in IDLE; vram_waddr and vram_wdata SHALL hold their last values when vram_we=0.
REQ-028 Throughput SHALL be one printable byte per 2 cycles when no line wrap occurs.
REQ-029 in_data and in_attr SHALL be ignored while in_ready=0.

Reset
REQ-030 While reset=1: in_ready=0, busy=1, vram_we=0, vram_waddr=0, vram_wdata=0, col=0, row=0, attr=0, state=CLRALL.
REQ-031 After reset deasserts, the block SHALL perform a full CLRALL with attr=0 before first asserting in_ready.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately, and the block SHALL restart the full clear sequence on release.

Verification
REQ-033 Release reset -> exactly 1200 writes, addresses 0..1199, wdata 16'h0020, then in_ready=1.
REQ-034 Send 'A' (0x41) with attr 0x1C at cursor (0,0) -> one write, addr 0, wdata 16'h1C41; next write for 'B' goes to addr 1.
REQ-035 Send 40 printable bytes from col 0 of row 29 -> writes at 1160..1199, then 40 clear writes at 0..39; cursor ends at (0,0).
REQ-036 Cursor at (2,5) (addr 85), send BS -> no write; next 'x' writes addr 84. BS at col 0 -> col stays 0.
REQ-037 Send CR then LF from (3,17) -> 40 clear writes at 160..199; next char writes addr 160.
REQ-038 FF with attr 0x07 -> 1200 writes of 16'h0720; assert reset at write 500 -> vram_we=0 at once; a full 1200-write clear with attr 0 follows release.

Source files
------------

// File: rtl/vram_console.sv
// vram_console: turns a stream of character bytes into writes to a
// text-mode video RAM. It keeps a cursor and an attribute byte and
// handles CR, LF, BS and FF. A new line is cleared on entry, and after
// every reset the whole screen is cleared.
//
// Ports:
//   clk        - single clock, also the video RAM write clock
//   reset      - asynchronous active-high reset
//   in_data    - character byte
//   in_valid   - in_data holds a byte
//   in_ready   - block can accept a byte (high only when idle)
//   in_attr    - attribute byte, sampled with each accepted byte
//   vram_waddr - cell address, row*COLS+col
//   vram_wdata - {attr, char}
//   vram_we    - write strobe
//   busy       - inverse of in_ready
module vram_console #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_attr,
  output logic [10:0] vram_waddr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  output logic        busy
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [10:0]   COLS_A    = 11'(COLS);
  localparam logic [10:0]   LINE_LAST = 11'(COLS - 1);
  localparam logic [10:0]   CELL_LAST = 11'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUT     = 2'd1,
    LINECLR = 2'd2,
    CLRALL  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    attr_q, attr_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          vram_we_q, vram_we_d;
  logic [10:0]   vram_waddr_q, vram_waddr_d;
  logic [15:0]   vram_wdata_q, vram_wdata_d;

  logic          accept_s;
  logic          printable_s;
  logic [RW-1:0] row_inc_s;
  logic [10:0]   base_cur_s;
  logic [10:0]   base_inc_s;

  // Accept decode, wrapped row increment and line base addresses.
  always_comb begin
    accept_s    = in_valid & in_ready_q;
    printable_s = (in_data >= 8'h20) && (in_data <= 8'h7E);
    if (row_q == ROW_LAST) begin
      row_inc_s = '0;
    end else begin
      row_inc_s = row_q + RW'(1);
    end
    base_cur_s = 11'(row_q) * COLS_A;
    base_inc_s = 11'(row_inc_s) * COLS_A;
  end

  // Next-state logic. Write outputs are computed for the state being
  // entered, so the strobe is visible during PUT/LINECLR/CLRALL and never
  // during IDLE.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    attr_d       = attr_q;
    cnt_d        = cnt_q;
    vram_we_d    = 1'b0;
    vram_waddr_d = vram_waddr_q;
    vram_wdata_d = vram_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          attr_d = in_attr;
          if (printable_s) begin
            state_d      = PUT;
            vram_we_d    = 1'b1;
            vram_waddr_d = base_cur_s + 11'(col_q);
            vram_wdata_d = {in_attr, in_data};
          end else begin
            case (in_data)
              8'h0A: begin
                col_d        = '0;
                row_d        = row_inc_s;
                cnt_d        = 11'd0;
                state_d      = LINECLR;
                vram_we_d    = 1'b1;
                vram_waddr_d = base_inc_s;
                vram_wdata_d = {in_attr, 8'h20};
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d = col_q - CW'(1);
                end else begin
                  col_d = col_q;
                end
              end
              8'h0C: begin
                col_d        = '0;
                row_d        = '0;
                cnt_d        = 11'd0;
                state_d      = CLRALL;
                vram_we_d    = 1'b1;
                vram_waddr_d = 11'd0;
                vram_wdata_d = {in_attr, 8'h20};
              end
              default: state_d = IDLE;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      PUT: begin
        if (col_q == COL_LAST) begin
          col_d        = '0;
          row_d        = row_inc_s;
          cnt_d        = 11'd0;
          state_d      = LINECLR;
          vram_we_d    = 1'b1;
          vram_waddr_d = base_inc_s;
          vram_wdata_d = {attr_q, 8'h20};
        end else begin
          col_d   = col_q + CW'(1);
          state_d = IDLE;
        end
      end
      LINECLR: begin
        if (cnt_q == LINE_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d        = cnt_q + 11'd1;
          vram_we_d    = 1'b1;
          vram_waddr_d = base_cur_s + cnt_q + 11'd1;
          vram_wdata_d = {attr_q, 8'h20};
        end
      end
      CLRALL: begin
        // Straight out of reset no write is in flight yet, so cell 0 is
        // issued first; otherwise the clear is already running.
        if (!vram_we_q) begin
          cnt_d        = 11'd0;
          vram_we_d    = 1'b1;
          vram_waddr_d = 11'd0;
          vram_wdata_d = {attr_q, 8'h20};
        end else if (cnt_q == CELL_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d        = cnt_q + 11'd1;
          vram_we_d    = 1'b1;
          vram_waddr_d = cnt_q + 11'd1;
          vram_wdata_d = {attr_q, 8'h20};
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset lands in CLRALL to force a full clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLRALL;
      col_q        <= '0;
      row_q        <= '0;
      attr_q       <= 8'h00;
      cnt_q        <= 11'd0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b1;
      vram_we_q    <= 1'b0;
      vram_waddr_q <= 11'd0;
      vram_wdata_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      attr_q       <= attr_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      vram_we_q    <= vram_we_d;
      vram_waddr_q <= vram_waddr_d;
      vram_wdata_q <= vram_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign vram_we    = vram_we_q;
  assign vram_waddr = vram_waddr_q;
  assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vram_console.sv
// Scoreboard bench for vram_console: expected writes are queued before each
// stimulus byte and a negedge monitor pops and compares every vram_we.
module tb_vram_console;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_attr;
  logic [10:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic        vram_we;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [26:0] sb[$];

  vram_console #(.COLS(40), .ROWS(30)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_attr(in_attr), .vram_waddr(vram_waddr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void push(input int a, input logic [15:0] d);
    logic [31:0] av;
    av = a;
    sb.push_back({av[10:0], d});
  endfunction

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [26:0] exp;
    if (vram_we === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got %h:%h want none", vram_waddr, vram_wdata);
      end else begin
        exp = sb.pop_front();
        check("write", {5'd0, vram_waddr, vram_wdata}, {5'd0, exp});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      in_data  = b;
      in_attr  = a;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_drained"}, sb.size(), 32'd0);
  endtask

  task automatic push_line(input int r, input logic [7:0] a);
    for (int c = 0; c < 40; c++) push(r * 40 + c, {a, 8'h20});
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] ch;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_attr  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_we", {31'd0, vram_we}, 32'd0);
    check("rst_waddr", {21'd0, vram_waddr}, 32'd0);
    check("rst_wdata", {16'd0, vram_wdata}, 32'd0);

    // Power-up clear; a pending byte is held on the input and must be ignored.
    for (int i = 0; i < 1200; i++) push(i, 16'h0020);
    in_valid = 1'b1;
    in_data  = 8'h41;
    in_attr  = 8'hFF;
    reset    = 1'b0;
    wait_idle("init_clear");
    in_valid = 1'b0;
    check("init_busy", {31'd0, busy}, 32'd0);

    // First characters and two-cycle throughput.
    push(0, 16'h1C41);
    send(8'h41, 8'h1C);
    push(1, 16'h1C42);
    send(8'h42, 8'h1C);
    @(negedge clk);
    check("put_busy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("put_ready_2cyc", {31'd0, in_ready}, 32'd1);

    // Walk down to row 29 with LFs, each clearing the new row.
    send(8'h0D, 8'h1C);
    for (int r = 1; r < 30; r++) begin
      push_line(r, 8'h1C);
      send(8'h0A, 8'h1C);
    end
    wait_idle("walk");

    // Fill row 29: wrap clears row 0 and parks the cursor at (0,0).
    for (int i = 0; i < 40; i++) begin
      ch = 8'h61 + 8'(i % 26);
      push(1160 + i, {8'h2E, ch});
      if (i == 39) push_line(0, 8'h2E);
      send(ch, 8'h2E);
    end
    wait_idle("wrap");
    push(0, 16'h1C5A);
    send(8'h5A, 8'h1C);

    // Backspace at (2,5) and at column 0.
    push_line(1, 8'h1C);
    send(8'h0A, 8'h1C);
    push_line(2, 8'h1C);
    send(8'h0A, 8'h1C);
    for (int i = 0; i < 5; i++) begin
      push(80 + i, {8'h1C, 8'h30 + 8'(i)});
      send(8'h30 + 8'(i), 8'h1C);
    end
    send(8'h08, 8'h1C);
    push(84, 16'h1C78);
    send(8'h78, 8'h1C);
    send(8'h0D, 8'h1C);
    send(8'h08, 8'h1C);
    push(80, 16'h1C79);
    send(8'h79, 8'h1C);
    wait_idle("bs");

    // CR + LF from (3,17) clears row 4.
    push_line(3, 8'h1C);
    send(8'h0A, 8'h1C);
    for (int i = 0; i < 17; i++) begin
      push(120 + i, {8'h1C, 8'h61 + 8'(i)});
      send(8'h61 + 8'(i), 8'h1C);
    end
    send(8'h0D, 8'h1C);
    push_line(4, 8'h1C);
    send(8'h0A, 8'h1C);
    push(160, 16'h1C6B);
    send(8'h6B, 8'h1C);

    // Ignored bytes and printable range edges.
    send(8'h01, 8'h1C);
    send(8'h7F, 8'h1C);
    push(161, 16'h1C20);
    send(8'h20, 8'h1C);
    push(162, 16'h1C7E);
    send(8'h7E, 8'h1C);
    wait_idle("misc");

    // Form feed clear interrupted by reset after 500 writes.
    for (int i = 0; i < 1200; i++) push(i, 16'h0720);
    send(8'h0C, 8'h07);
    base = wr_count;
    n = 0;
    while (wr_count < base + 500 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("ff_500_writes", wr_count - base, 32'd500);
    reset = 1'b1;
    #1;
    check("abort_we", {31'd0, vram_we}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_waddr", {21'd0, vram_waddr}, 32'd0);
    sb.delete();
    @(negedge clk);
    check("abort_we_held", {31'd0, vram_we}, 32'd0);
    for (int i = 0; i < 1200; i++) push(i, 16'h0020);
    reset = 1'b0;
    wait_idle("reclear");

    // Cursor and attribute restart from zero after the abort.
    push(0, 16'h5541);
    send(8'h41, 8'h55);
    wait_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
